// File: rtl/lsu_if.sv
// Pipeline/data-memory bundle for the load/store unit.
// slave = the LSU itself; master = pipeline plus memory environment.
interface lsu_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [XLEN-1:0]       req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_rdata;
  logic                  resp_fault;
  logic                  mem_we;
  logic [XLEN/8-1:0]     mem_byteEnable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [XLEN-1:0]       mem_wd;
  logic [XLEN-1:0]       mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_we, mem_byteEnable, mem_address, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_we, mem_byteEnable, mem_address, mem_wd
  );
endinterface

// File: rtl/lsu.sv
// MEM-stage load/store unit driving a synchronous-read data memory.
// Define LSU_MISALIGNED_EN to split word-crossing accesses; otherwise misaligned H/W fault.
module lsu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);
  localparam int unsigned NLANE = XLEN / 8;
  localparam int unsigned AW2   = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_WAIT = 2'd1
`ifdef LSU_MISALIGNED_EN
    ,
    S_LD_HI   = 2'd2,
    S_ST_HI   = 2'd3
`endif
  } state_t;

  state_t          r_state;
  logic [AW2-1:0]  r_addr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_wdata;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_fault;
`ifdef LSU_MISALIGNED_EN
  logic [XLEN-1:0] r_lo;
`endif

  logic [AW2-1:0]        w_addr;
  logic [2:0]            w_funct3;
  logic [XLEN-1:0]       w_wdata;
  logic [1:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_word_a;
  logic [ADDR_WIDTH-1:0] w_word_b;
  logic [2:0]            w_size;
  logic                  w_split;
  logic                  w_fault;
  logic [2*NLANE-1:0]    w_mask_base;
  logic [2*NLANE-1:0]    w_mask_wide;
  logic [2*XLEN-1:0]     w_data_wide;
  logic                  w_unused;

  // In IDLE the live request is decoded; afterwards the latched copy is.
  assign w_addr   = (r_state == S_IDLE) ? bus.req_addr[AW2-1:0] : r_addr;
  assign w_funct3 = (r_state == S_IDLE) ? bus.req_funct3        : r_funct3;
  assign w_wdata  = (r_state == S_IDLE) ? bus.req_wdata         : r_wdata;

  assign w_off    = w_addr[1:0];
  assign w_word_a = w_addr[AW2-1:2];
  assign w_word_b = w_word_a + ADDR_WIDTH'(1);

  always_comb begin
    w_size      = 3'd4;
    w_mask_base = (2*NLANE)'({NLANE{1'b1}});
    case (w_funct3[1:0])
      2'b00: begin
        w_size      = 3'd1;
        w_mask_base = (2*NLANE)'(1);
      end
      2'b01: begin
        w_size      = 3'd2;
        w_mask_base = (2*NLANE)'(3);
      end
      default: ;
    endcase
  end

  assign w_mask_wide = w_mask_base << w_off;
  assign w_data_wide = {{XLEN{1'b0}}, w_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGNED_EN
  logic [3:0] w_reach;
  assign w_reach = 4'(w_off) + 4'(w_size);
  assign w_split = (w_reach > 4'd4);
  assign w_fault = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111)
                 || (bus.req_we && w_funct3[2]);
  assign w_unused = ^{bus.req_addr[XLEN-1:AW2]};
`else
  assign w_split = 1'b0;
  assign w_fault = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111)
                 || (bus.req_we && w_funct3[2])
                 || ((w_funct3[1:0] == 2'b01) && w_off[0])
                 || ((w_funct3[1:0] == 2'b10) && (w_off != 2'b00));
  assign w_unused = ^{bus.req_addr[XLEN-1:AW2], w_mask_wide[2*NLANE-1:NLANE],
                      w_data_wide[2*XLEN-1:XLEN], w_size};
`endif

  // Shift the two-word window down to the addressed byte, then extend.
  function automatic logic [XLEN-1:0] f_format(input logic [2*XLEN-1:0] raw,
                                               input logic [1:0]        off,
                                               input logic [2:0]        f3);
    logic [2*XLEN-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   f_format = f3[2] ? XLEN'(sh[7:0])  : {{(XLEN-8){sh[7]}},  sh[7:0]};
      2'b01:   f_format = f3[2] ? XLEN'(sh[15:0]) : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: f_format = sh[XLEN-1:0];
    endcase
  endfunction

  // Memory port: combinational from the request and the current state.
  always_comb begin
    bus.mem_we         = 1'b0;
    bus.mem_byteEnable = '0;
    bus.mem_address    = w_word_a;
    bus.mem_wd         = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && bus.req_we && !w_fault) begin
          bus.mem_we         = 1'b1;
          bus.mem_byteEnable = w_mask_wide[NLANE-1:0];
          bus.mem_wd         = w_data_wide[XLEN-1:0];
        end
      end
      S_LD_WAIT: begin
        if (w_split) bus.mem_address = w_word_b;
      end
`ifdef LSU_MISALIGNED_EN
      S_ST_HI: begin
        bus.mem_we         = 1'b1;
        bus.mem_byteEnable = w_mask_wide[2*NLANE-1:NLANE];
        bus.mem_address    = w_word_b;
        bus.mem_wd         = w_data_wide[2*XLEN-1:XLEN];
      end
`endif
      default: ;
    endcase
    if (reset) begin
      bus.mem_we         = 1'b0;
      bus.mem_byteEnable = '0;
    end
  end

  // Control FSM with registered completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      r_lo         <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr   <= bus.req_addr[AW2-1:0];
            r_funct3 <= bus.req_funct3;
            r_wdata  <= bus.req_wdata;
            if (w_fault) begin
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
            end else if (bus.req_we) begin
`ifdef LSU_MISALIGNED_EN
              if (w_split) r_state <= S_ST_HI;
              else         r_resp_valid <= 1'b1;
`else
              r_resp_valid <= 1'b1;
`endif
            end else begin
              r_state <= S_LD_WAIT;
            end
          end
        end
        S_LD_WAIT: begin
`ifdef LSU_MISALIGNED_EN
          if (w_split) begin
            r_lo    <= bus.mem_rd;
            r_state <= S_LD_HI;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= f_format({{XLEN{1'b0}}, bus.mem_rd}, w_off, w_funct3);
            r_state      <= S_IDLE;
          end
`else
          r_resp_valid <= 1'b1;
          r_resp_rdata <= f_format({{XLEN{1'b0}}, bus.mem_rd}, w_off, w_funct3);
          r_state      <= S_IDLE;
`endif
        end
`ifdef LSU_MISALIGNED_EN
        S_LD_HI: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= f_format({bus.mem_rd, r_lo}, w_off, w_funct3);
          r_state      <= S_IDLE;
        end
        S_ST_HI: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_fault = r_resp_fault;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-enabled synchronous-read memory model.
// Expectations follow LSU_MISALIGNED_EN when the bench is built with it.
module tb_lsu;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  lsu_if #(.XLEN(32), .ADDR_WIDTH(8)) bus ();
  lsu #(.XLEN(32), .ADDR_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Data memory: write on enabled lanes, read data one cycle after the address.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q       = 32'h0;
  logic        mem_loaded = 1'b0;
  int          wr_count   = 0;

  always @(posedge clk) begin
    if (reset && !mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteEnable[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_wd[8*b +: 8];
      wr_count <= wr_count + 1;
    end
    rd_q <= mem[bus.mem_address];
  end
  assign bus.mem_rd = rd_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Memory-port samples: accept cycle and the cycle after it.
  logic        a_we, h_we;
  logic [3:0]  a_be, h_be;
  logic [7:0]  a_addr, h_addr;
  logic [31:0] a_wd, h_wd;
  logic        ready_at_resp;

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
    a_we = bus.mem_we; a_be = bus.mem_byteEnable; a_addr = bus.mem_address; a_wd = bus.mem_wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 99; rdata = 32'h0; fault = 1'b0; ready_at_resp = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        h_we = bus.mem_we; h_be = bus.mem_byteEnable; h_addr = bus.mem_address; h_wd = bus.mem_wd;
      end
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; fault = bus.resp_fault; ready_at_resp = bus.req_ready;
        break;
      end
    end
    check({tag, "_lat"},   32'(lat),   32'(exp_lat));
    check({tag, "_rdata"}, rdata,      exp_rdata);
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  int snap;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset: outputs cleared and memory port idle even with a pending store.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    #1;
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_be",     32'(bus.mem_byteEnable), 32'd0);
    check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata",  bus.resp_rdata, 32'd0);
    check("rst_rfault", 32'(bus.resp_fault), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    check("sw10_we",   32'(a_we), 32'd1);
    check("sw10_addr", 32'(a_addr), 32'h04);
    check("sw10_be",   32'(a_be), 32'hF);
    check("sw10_wd",   a_wd, 32'hDEADBEEF);
    check("sw10_rdy",  32'(ready_at_resp), 32'd1);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    xact("sb13", 1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0, 1);
    check("sb13_be", 32'(a_be), 32'h8);
    check("sb13_wd", a_wd, 32'h80000000);
    xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2);

    xact("sh12", 1'b1, 3'b001, 32'h12, 32'hFFFFA5B6, 32'h0, 1'b0, 1);
    check("sh12_be", 32'(a_be), 32'hC);
    check("sh12_wd", a_wd, 32'hA5B60000);
    xact("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFA5B6, 1'b0, 2);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000A5B6, 1'b0, 2);
    xact("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 2);

    // Word-crossing store/load and the word-address wrap.
    snap = wr_count;
`ifdef LSU_MISALIGNED_EN
    xact("sw0e", 1'b1, 3'b010, 32'h0E, 32'h11223344, 32'h0, 1'b0, 2);
    check("sw0e_a_be",   32'(a_be), 32'hC);
    check("sw0e_a_addr", 32'(a_addr), 32'h03);
    check("sw0e_a_wd",   a_wd, 32'h33440000);
    check("sw0e_h_we",   32'(h_we), 32'd1);
    check("sw0e_h_be",   32'(h_be), 32'h3);
    check("sw0e_h_addr", 32'(h_addr), 32'h04);
    check("sw0e_h_wd",   h_wd, 32'h00001122);
    xact("lw0e", 1'b0, 3'b010, 32'h0E, 32'h0, 32'h11223344, 1'b0, 3);
    xact("lw0c", 1'b0, 3'b010, 32'h0C, 32'h0, 32'h33440003, 1'b0, 2);
    xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5B61122, 1'b0, 2);
    xact("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFFB611, 1'b0, 2);
    xact("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0000C0DE, 1'b0, 3);
    check("lw3fe_a_addr", 32'(a_addr), 32'hFF);
    check("lw3fe_h_addr", 32'(h_addr), 32'h00);
    check("lw3fe_h_we",   32'(h_we), 32'd0);
`else
    xact("sw0e", 1'b1, 3'b010, 32'h0E, 32'h11223344, 32'h0, 1'b1, 1);
    check("sw0e_we", 32'(a_we), 32'd0);
    check("sw0e_wr", 32'(wr_count), 32'(snap));
    xact("lw0c", 1'b0, 3'b010, 32'h0C, 32'h0, 32'hC0DE0003, 1'b0, 2);
    xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5B6BEEF, 1'b0, 2);
    xact("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    xact("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1'b1, 1);
`endif

    // Illegal encodings fault without touching memory.
    snap = wr_count;
    xact("f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1);
    check("f3_011_we", 32'(a_we), 32'd0);
    xact("sbu", 1'b1, 3'b100, 32'h20, 32'hFF, 32'h0, 1'b1, 1);
    check("sbu_we", 32'(a_we), 32'd0);
    check("sbu_be", 32'(a_be), 32'd0);
    check("fault_wr", 32'(wr_count), 32'(snap));

    // Reset in the middle of an access abandons it.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b010;
`ifdef LSU_MISALIGNED_EN
    bus.req_we = 1'b1; bus.req_addr = 32'h21; bus.req_wdata = 32'hAABBCCDD;
`else
    bus.req_we = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'h0;
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rv0",   32'(bus.resp_valid), 32'd0);
    snap = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) snap++;
    end
    check("midrst_norv", 32'(snap), 32'd0);
`ifdef LSU_MISALIGNED_EN
    check("midrst_wordA", mem[8], 32'hBBCCDD08);
    check("midrst_wordB", mem[9], 32'hC0DE0009);
`endif
    xact("post_rst_lw", 1'b0, 3'b010, 32'h10, 32'h0,
`ifdef LSU_MISALIGNED_EN
         32'hA5B61122,
`else
         32'hA5B6BEEF,
`endif
         1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MEM stage. It is the initiator on the data-memory port: it takes one load or store request at a time, drives word address, write enable, byte enables and lane-aligned write data, and captures the synchronous read data one cycle later. It returns sign- or zero-extended load results, or a store/fault completion, to the pipeline. Optionally, it splits word-crossing accesses into two memory operations.

## Interface
Parameters:
- XLEN, 32, data width; byte lanes = XLEN/8 (only 32 supported).
- ADDR_WIDTH, 8, word-address width of the memory port.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (state IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  request rejected; no memory side effect.
- mem_we  out  1  memory write enable.
- mem_byteEnable  out  XLEN/8  per-lane write enable.
- mem_address  out  ADDR_WIDTH  word address.
- mem_wd  out  XLEN  lane-aligned write data.
- mem_rd  in  XLEN  read data. It is valid the cycle after the address was presented with mem_we=0.

## Operation
- Memory-side ports are combinational from the request and the current state. A request is accepted on `req_valid && req_ready`.
- Address decomposition:
  - offset = req_addr[1:0].
  - word A = req_addr[ADDR_WIDTH+1:2].
  - word B = A+1, modulo 2^ADDR_WIDTH (wraps to 0).
- Size: B = 1, H = 2, W = 4. An access is split when offset + size > 4.
- Store lanes:
  - 8-bit mask = size-bit ones << offset; 64-bit data = req_wdata << 8*offset.
  - Low halves go to A; high halves go to B.
- Load data: {rd_B, rd_A} >> 8*offset, truncated to size. B/H are sign-extended; BU/HU are zero-extended.
- Faults: req_funct3 in {011, 110, 111}, or a store funct3 above 010. A faulting request issues no access: mem_we = 0 and mem_byteEnable = 0.
- When idle, or in a non-issuing cycle: mem_we = 0, mem_byteEnable = 0, mem_address = A of the current request.
- FSM states:
  - IDLE: accept. A store writes A, then goes to ST_HI if split, else completes. A load reads A and goes to LD_WAIT. A fault completes.
  - LD_WAIT: if not split, format mem_rd and complete, then go to IDLE. If split, latch mem_rd into lo_q, issue a read of B, and go to LD_HI.
  - LD_HI: combine lo_q and mem_rd, complete, and go to IDLE.
  - ST_HI: write the B portion, complete, and go to IDLE.
- Completion: resp_valid, resp_rdata and resp_fault are registered, so resp_valid is high the cycle after the completing state. There is no response backpressure.

## Timing
- Reset (synchronous) results in:
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_fault = 0, lo_q = 0.
  - Memory ports idle (mem_we = 0) while reset is high.
- Latency from the accept cycle to resp_valid:
  - aligned store: 1
  - fault: 1
  - aligned load: 2
  - split store: 2
  - split load: 3
- req_ready is high in the cycle resp_valid pulses, so back-to-back requests are supported.
- Reset mid-operation abandons the access. In ST_HI, word B is not written. No resp_valid is produced for the abandoned request.

## Configuration
- LSU_MISALIGNED_EN defined: split accesses run as above. Non-split misaligned accesses (e.g. H at offset 1) complete in a single access.
- LSU_MISALIGNED_EN undefined:
  - Any naturally misaligned access faults: H with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - LD_HI and ST_HI are not built.
  - Faulting accesses have 1-cycle latency with resp_fault = 1 and no memory write.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10:
  - The store drives mem_address 0x04, byteEnable 1111; resp at +1.
  - The load returns 0xDEADBEEF at +2.
- SB 0x80 @0x13 (byteEnable 1000, mem_wd 0x80000000):
  - LB @0x13 → 0xFFFFFF80; LBU → 0x00000080.
  - Bytes 0x10–0x12 are unchanged.
- SH 0xA5B6 @0x12 (byteEnable 1100), then LH → 0xFFFFA5B6 and LHU → 0x0000A5B6.
- With LSU_MISALIGNED_EN, SW 0x11223344 @0x0E:
  - Word 3 is written with byteEnable 1100; word 4 with byteEnable 0011. resp at +2.
  - LW @0x0E → 0x11223344 at +3.
  - Without the macro: resp_fault = 1 at +1, and a subsequent aligned read shows memory unchanged.
- LW @0x3FE (ADDR_WIDTH 8, macro on): second read uses mem_address 0x00.
  - Separately, funct3 011 → resp_fault = 1 with mem_we never asserted.
- Assert reset during the ST_HI cycle: word B is unchanged, no resp_valid is produced, and req_ready = 1 on the first cycle after reset.
